// File: rtl/cpu_check_pkg.sv
// Shared types and width helpers for the CPU run controller/checker.
package cpu_check_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_CHECK,
      S_DONE
   } chk_state_t;

   localparam int STATE_W = 3;

   // Counter width that never collapses to zero bits for a count of 1.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/halt_detector.sv
// Flags a halt once the PC has matched the previous cycle's PC for HALT_STABLE
// consecutive cycles; the first cycle after clr drops only samples the PC.
module halt_detector #(
   parameter int ADDR_WIDTH  = 32,
   parameter int HALT_STABLE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [ADDR_WIDTH-1:0] pc,
   output logic                  halt
);

   localparam int CW = $clog2(HALT_STABLE);
   localparam logic [CW-1:0] LAST = CW'(HALT_STABLE - 1);

   logic                  armed;
   logic [ADDR_WIDTH-1:0] prev_pc;
   logic [CW-1:0]         same_cnt;
   logic                  same;

   assign same = (pc == prev_pc);

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         armed    <= 1'b0;
         prev_pc  <= '0;
         same_cnt <= '0;
      end else if (!armed) begin
         armed    <= 1'b1;
         prev_pc  <= pc;
         same_cnt <= '0;
      end else begin
         prev_pc <= pc;
         if (!same)
            same_cnt <= '0;
         else if (same_cnt != LAST)
            same_cnt <= same_cnt + 1'b1;
      end
   end

   // Combinational so the run can end in the very cycle the last match is seen.
   assign halt = armed && !clr && same && (same_cnt == LAST);

endmodule

// File: rtl/cpu_run_checker.sv
// Run controller/checker: resets the CPU, runs it for a bounded budget (or until
// halt), then compares the observed register channels one per cycle.
module cpu_run_checker
   import cpu_check_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int NUM_CHECKS   = 4,
   parameter int RESET_CYCLES = 1,
   parameter int RUN_CYCLES   = 50,
   parameter int HALT_DETECT  = 1,
   parameter int HALT_STABLE  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   output logic                             cpu_rst,
   input  logic [ADDR_WIDTH-1:0]            pc,
   input  logic [NUM_CHECKS*DATA_WIDTH-1:0] obs_data,
   input  logic [NUM_CHECKS*DATA_WIDTH-1:0] exp_data,
   input  logic [NUM_CHECKS-1:0]            check_mask,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic [NUM_CHECKS-1:0]            fail_vec,
   output logic                             halted,
   output logic [$clog2(RUN_CYCLES+1)-1:0]  run_cycles
);

   localparam int RUN_W = $clog2(RUN_CYCLES + 1);
   localparam int RST_W = clog2_min1(RESET_CYCLES);
   localparam int IDX_W = clog2_min1(NUM_CHECKS);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);

   chk_state_t state, state_nxt;

   logic [RST_W-1:0]      rst_cnt;
   logic [IDX_W-1:0]      chk_idx;
   logic [NUM_CHECKS-1:0] mism;
   logic [NUM_CHECKS-1:0] fail_upd;
   logic                  halt;
   logic                  halt_hit;
   logic                  rst_end;
   logic                  run_end;
   logic                  chk_end;

   halt_detector #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .HALT_STABLE (HALT_STABLE)
   ) u_halt (
      .clk  (clk),
      .rst  (rst),
      .clr  (state != S_RUN),
      .pc   (pc),
      .halt (halt)
   );

   assign halt_hit = (HALT_DETECT != 0) && halt;
   assign rst_end  = (rst_cnt == RST_LAST);
   assign run_end  = (run_cycles == RUN_LAST);
   assign chk_end  = (chk_idx == IDX_LAST);

   for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_cmp
      assign mism[i] = check_mask[i] &&
                       (obs_data[i*DATA_WIDTH +: DATA_WIDTH] != exp_data[i*DATA_WIDTH +: DATA_WIDTH]);
   end

   // fail_vec with the current channel folded in, so pass can be registered
   // on the same edge that enters DONE.
   always_comb begin
      fail_upd          = fail_vec;
      fail_upd[chk_idx] = mism[chk_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cpu_rst   = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RESET;
         end
         S_RESET: begin
            busy = 1'b1;
            if (rst_end) state_nxt = S_RUN;
         end
         S_RUN: begin
            cpu_rst = 1'b0;
            busy    = 1'b1;
            if (halt_hit || run_end) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            cpu_rst = 1'b0;
            busy    = 1'b1;
            if (chk_end) state_nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_nxt = S_RESET;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rst_cnt    <= '0;
         chk_idx    <= '0;
         run_cycles <= '0;
         fail_vec   <= '0;
         pass       <= 1'b0;
         halted     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  rst_cnt    <= '0;
                  chk_idx    <= '0;
                  run_cycles <= '0;
                  fail_vec   <= '0;
                  pass       <= 1'b0;
                  halted     <= 1'b0;
               end
            end
            S_RESET: begin
               rst_cnt <= rst_end ? '0 : rst_cnt + 1'b1;
            end
            S_RUN: begin
               if (run_cycles != RUN_MAX) run_cycles <= run_cycles + 1'b1;
               if (halt_hit) halted <= 1'b1;
            end
            S_CHECK: begin
               fail_vec <= fail_upd;
               if (chk_end) begin
                  chk_idx <= '0;
                  pass    <= ~|fail_upd;
               end else begin
                  chk_idx <= chk_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_checker.sv
// Directed bench: one checker without halt detection, one with; results are
// checked by a scoreboard monitor that pops an expectation on each done rise.
module tb_cpu_run_checker;

   logic         clk = 1'b0;
   logic         rst;
   logic         start0, start1;
   logic         cpu_rst0, cpu_rst1;
   logic [31:0]  pc = '0;
   logic [127:0] obs, exp_v;
   logic [3:0]   mask;
   logic         busy0, busy1, done0, done1, pass0, pass1, halted0, halted1;
   logic [3:0]   fail_vec0, fail_vec1;
   logic [5:0]   run_cycles0, run_cycles1;

   int checks = 0;
   int errors = 0;
   int sel = 0;
   int pc_mode = 0;
   int rc = 0;

   typedef struct {
      string      nm;
      logic       pass;
      logic [3:0] fv;
      logic       halted;
      int         rcyc;
   } sb_t;

   sb_t q0[$];
   sb_t q1[$];

   always #5 clk = ~clk;

   cpu_run_checker #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CHECKS(4), .RESET_CYCLES(1),
      .RUN_CYCLES(50), .HALT_DETECT(0), .HALT_STABLE(4)
   ) dut0 (
      .clk(clk), .rst(rst), .start(start0), .cpu_rst(cpu_rst0), .pc(pc),
      .obs_data(obs), .exp_data(exp_v), .check_mask(mask), .busy(busy0),
      .done(done0), .pass(pass0), .fail_vec(fail_vec0), .halted(halted0),
      .run_cycles(run_cycles0)
   );

   cpu_run_checker #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CHECKS(4), .RESET_CYCLES(1),
      .RUN_CYCLES(50), .HALT_DETECT(1), .HALT_STABLE(4)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start1), .cpu_rst(cpu_rst1), .pc(pc),
      .obs_data(obs), .exp_data(exp_v), .check_mask(mask), .busy(busy1),
      .done(done1), .pass(pass1), .fail_vec(fail_vec1), .halted(halted1),
      .run_cycles(run_cycles1)
   );

   // PC model: rc is the 1-based RUN/CHECK cycle number of the selected DUT.
   always begin
      @(posedge clk);
      #1;
      if ((sel == 0 ? cpu_rst0 : cpu_rst1) == 1'b1) rc = 0;
      else rc = rc + 1;
      case (pc_mode)
         1:       pc = (rc < 10) ? 32'(rc) : 32'h20;
         2:       pc = (rc <= 4) ? 32'd7 : 32'(100 + rc);
         default: pc = pc + 32'd4;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, req, req);
      end
   endtask

   // {cpu_rst, busy, done, pass, halted, fail_vec, run_cycles}
   function automatic int status(input int k);
      if (k == 0) return int'({cpu_rst0, busy0, done0, pass0, halted0, fail_vec0, run_cycles0});
      return int'({cpu_rst1, busy1, done1, pass1, halted1, fail_vec1, run_cycles1});
   endfunction

   localparam int ST_RESET = int'({1'b1, 14'd0});

   task automatic set_start(input int k, input logic v);
      if (k == 0) start0 = v;
      else        start1 = v;
   endtask

   task automatic monitor();
      logic d0q = 1'b0;
      logic d1q = 1'b0;
      sb_t  e;
      forever begin
         @(negedge clk);
         if (done0 && !d0q) begin
            if (q0.size() == 0) chk("dut0_unexpected_done", 1, 0);
            else begin
               e = q0.pop_front();
               chk({e.nm, "_pass"},       int'(pass0),       int'(e.pass));
               chk({e.nm, "_fail_vec"},   int'(fail_vec0),   int'(e.fv));
               chk({e.nm, "_halted"},     int'(halted0),     int'(e.halted));
               chk({e.nm, "_run_cycles"}, int'(run_cycles0), e.rcyc);
            end
         end
         if (done1 && !d1q) begin
            if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
            else begin
               e = q1.pop_front();
               chk({e.nm, "_pass"},       int'(pass1),       int'(e.pass));
               chk({e.nm, "_fail_vec"},   int'(fail_vec1),   int'(e.fv));
               chk({e.nm, "_halted"},     int'(halted1),     int'(e.halted));
               chk({e.nm, "_run_cycles"}, int'(run_cycles1), e.rcyc);
            end
         end
         d0q = done0;
         d1q = done1;
      end
   endtask

   // Latency counts posedges from the one sampling start through the one raising done.
   task automatic run_case(input int k, input string nm, input logic restart,
                           input logic e_pass, input logic [3:0] e_fv, input logic e_halt,
                           input int e_rc, input int e_lat, input int e_low, input int busy_at);
      sb_t  e;
      int   lat;
      int   low;
      logic got;
      e.nm = nm; e.pass = e_pass; e.fv = e_fv; e.halted = e_halt; e.rcyc = e_rc;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      sel = k;
      set_start(k, 1'b1);
      tick();
      set_start(k, 1'b0);
      lat = 1;
      low = 0;
      got = 1'b0;
      if (restart) chk({nm, "_restart_cleared"}, status(k), int'({1'b1, 1'b1, 13'd0}));
      for (int c = 0; c < 300 && !got; c++) begin
         if (lat == busy_at) set_start(k, 1'b1);
         tick();
         set_start(k, 1'b0);
         lat++;
         if ((k == 0 ? cpu_rst0 : cpu_rst1) == 1'b0) low++;
         if ((k == 0 ? done0 : done1) == 1'b1) got = 1'b1;
      end
      chk({nm, "_done_seen"}, int'(got), 1);
      chk({nm, "_latency"}, lat, e_lat);
      chk({nm, "_cpu_rst_low"}, low, e_low);
   endtask

   task automatic run_until_low(input int k, input int target);
      int low;
      low = 0;
      set_start(k, 1'b1);
      tick();
      set_start(k, 1'b0);
      for (int c = 0; c < 300 && low < target; c++) begin
         tick();
         if ((k == 0 ? cpu_rst0 : cpu_rst1) == 1'b0) low++;
      end
      chk("abort_reached_point", low, target);
   endtask

   initial begin
      rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
      obs = {32'h44, 32'h33, 32'h22, 32'h11};
      exp_v = obs;
      mask = 4'hF;
      fork monitor(); join_none
      repeat (2) tick();
      chk("reset_dut0", status(0), ST_RESET);
      chk("reset_dut1", status(1), ST_RESET);
      rst = 1'b1;
      tick();

      // 1: full budget, all channels match; start pulse mid-RUN is ignored
      run_case(0, "t1", 1'b0, 1'b1, 4'b0000, 1'b0, 50, 56, 54, 10);

      // 2a: channel 2 mismatch, all channels compared
      obs[95:64] = 32'd5; exp_v[95:64] = 32'd0;
      run_case(0, "t2a", 1'b0, 1'b0, 4'b0100, 1'b0, 50, 56, 54, 0);
      repeat (3) tick();
      chk("t2a_results_hold", status(0), int'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 6'd50}));

      // 2b + restart from DONE: channel 2 masked out
      mask = 4'b1011;
      run_case(0, "t2b", 1'b1, 1'b1, 4'b0000, 1'b0, 50, 56, 54, 0);

      // 3: PC reaches 0x20 at RUN cycle 10 and holds -> halt at cycle 14
      mask = 4'hF; exp_v = obs; pc_mode = 1;
      run_case(1, "t3", 1'b0, 1'b1, 4'b0000, 1'b1, 14, 20, 18, 0);

      // 4: PC holds one comparison short of a halt, then moves on
      pc_mode = 2;
      run_case(1, "t4", 1'b0, 1'b1, 4'b0000, 1'b0, 50, 56, 54, 0);

      // 5: reset mid-RUN, then mid-CHECK with channel 0 already flagged
      pc_mode = 0;
      obs[31:0] = 32'd1; exp_v[31:0] = 32'd2;
      run_until_low(0, 20);
      rst = 1'b0;
      tick();
      chk("t5_run_abort_dut0", status(0), ST_RESET);
      chk("t5_run_abort_dut1", status(1), ST_RESET);
      rst = 1'b1;
      tick();
      run_until_low(0, 52);
      chk("t5_mid_check_fail_vec", int'(fail_vec0), 1);
      rst = 1'b0;
      tick();
      chk("t5_check_abort_dut0", status(0), ST_RESET);
      rst = 1'b1;
      repeat (3) tick();
      chk("t5_stays_idle", status(0), ST_RESET);

      chk("scoreboard_drained", q0.size() + q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
